// File: rtl/state_indicator_pkg.sv
// Shared types and default thresholds for the battery charge-state path.
package state_indicator_pkg;

    typedef enum logic [1:0] {
        ST_CRIT = 2'd0,
        ST_LOW  = 2'd1,
        ST_MID  = 2'd2,
        ST_FULL = 2'd3
    } state_t;

    localparam int BAT_W_DEF   = 5;
    localparam int TH_LOW_DEF  = 6;
    localparam int TH_MID_DEF  = 12;
    localparam int TH_FULL_DEF = 24;
    localparam int HYST_DEF    = 2;

endpackage

// File: rtl/state_indicator_level_classifier.sv
// Combinational raw charge level from a battery reading; readings exactly at a
// threshold belong to the higher level.
module level_classifier
    import state_indicator_pkg::*;
#(
    parameter int BAT_W   = BAT_W_DEF,
    parameter int TH_LOW  = TH_LOW_DEF,
    parameter int TH_MID  = TH_MID_DEF,
    parameter int TH_FULL = TH_FULL_DEF
) (
    input  logic [BAT_W-1:0] battery,
    output logic [1:0]       level
);

    localparam logic [BAT_W-1:0] TH_LOW_C  = BAT_W'(TH_LOW);
    localparam logic [BAT_W-1:0] TH_MID_C  = BAT_W'(TH_MID);
    localparam logic [BAT_W-1:0] TH_FULL_C = BAT_W'(TH_FULL);

    // Priority compare from the highest threshold down
    always_comb begin
        level = 2'd0;
        if (battery >= TH_FULL_C) begin
            level = 2'd3;
        end else if (battery >= TH_MID_C) begin
            level = 2'd2;
        end else if (battery >= TH_LOW_C) begin
            level = 2'd1;
        end else begin
            level = 2'd0;
        end
    end

endmodule

// File: rtl/state_indicator.sv
// Battery charge-state register with downward hysteresis, critical flag and
// one-cycle change pulse.
module state_indicator
    import state_indicator_pkg::*;
#(
    parameter int BAT_W   = BAT_W_DEF,
    parameter int TH_LOW  = TH_LOW_DEF,
    parameter int TH_MID  = TH_MID_DEF,
    parameter int TH_FULL = TH_FULL_DEF,
    parameter int HYST    = HYST_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [BAT_W-1:0] battery,
    output logic [1:0]       state,
    output logic             critical,
    output logic             changed
);

    // Threshold ordering and margins guarantee TH[state]-HYST never underflows
    if (!(TH_LOW > 0 && TH_LOW < TH_MID && TH_MID < TH_FULL && TH_FULL <= (2**BAT_W) - 1)) begin : g_bad_thresholds
        $fatal(1, "state_indicator: thresholds out of order or out of range");
    end
    if (!(HYST < TH_LOW && HYST < (TH_MID - TH_LOW) && HYST < (TH_FULL - TH_MID))) begin : g_bad_hyst
        $fatal(1, "state_indicator: hysteresis margin too large");
    end

    logic [1:0]     raw_s;
    logic [BAT_W:0] th_cur_s;
    logic [BAT_W:0] floor_s;
    state_t         next_s;
    state_t         state_r;
    logic           changed_r;

    level_classifier #(
        .BAT_W   (BAT_W),
        .TH_LOW  (TH_LOW),
        .TH_MID  (TH_MID),
        .TH_FULL (TH_FULL)
    ) u_level_classifier (
        .battery (battery),
        .level   (raw_s)
    );

    // Next state: rise immediately, fall only once below the current entry threshold minus margin
    always_comb begin
        th_cur_s = {(BAT_W+1){1'b0}};
        case (state_r)
            ST_LOW:  th_cur_s = (BAT_W+1)'(TH_LOW);
            ST_MID:  th_cur_s = (BAT_W+1)'(TH_MID);
            ST_FULL: th_cur_s = (BAT_W+1)'(TH_FULL);
            default: th_cur_s = {(BAT_W+1){1'b0}};
        endcase
        floor_s = th_cur_s - (BAT_W+1)'(HYST);

        next_s = state_r;
        if (raw_s > state_r) begin
            next_s = state_t'(raw_s);
        end else if ((raw_s < state_r) && ({1'b0, battery} < floor_s)) begin
            next_s = state_t'(raw_s);
        end else begin
            next_s = state_r;
        end
    end

    // State register and change pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_CRIT;
            changed_r <= 1'b0;
        end else begin
            state_r   <= next_s;
            changed_r <= (next_s != state_r);
        end
    end

    assign state    = state_r;
    assign critical = (state_r == ST_CRIT);
    assign changed  = changed_r;

endmodule

// File: tb/tb_state_indicator.sv
// Self-checking bench for state_indicator: directed plan plus random readings
// against an arithmetic reference model.
module tb_state_indicator;

    localparam int HYST = 2;

    logic       clk;
    logic       rst_n;
    logic [4:0] battery;
    logic [1:0] state;
    logic       critical;
    logic       changed;

    int n_checks;
    int n_fail;

    // Reference model state
    int m_state;
    int m_changed;
    int th_tab[4];

    state_indicator dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .battery  (battery),
        .state    (state),
        .critical (critical),
        .changed  (changed)
    );

    // Free-running clock, 10 time units per period
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int raw_of(input int b);
        if (b >= 24) return 3;
        if (b >= 12) return 2;
        if (b >= 6)  return 1;
        return 0;
    endfunction

    task automatic check_all(input string tag);
        check_eq({tag, ".state"}, int'(state), m_state);
        check_eq({tag, ".critical"}, int'(critical), (m_state == 0) ? 1 : 0);
        check_eq({tag, ".changed"}, int'(changed), m_changed);
    endtask

    // Apply one reading, take one edge, update the model, then compare
    task automatic step(input int b, input string tag);
        int r;
        int prev;
        battery = b[4:0];
        @(posedge clk);
        prev = m_state;
        r = raw_of(b);
        if (r > m_state) begin
            m_state = r;
        end else if (r < m_state && b < th_tab[m_state] - HYST) begin
            m_state = r;
        end
        m_changed = (m_state != prev) ? 1 : 0;
        #1;
        check_all(tag);
    endtask

    task automatic async_reset(input string tag);
        #2;
        rst_n = 1'b0;
        m_state = 0;
        m_changed = 0;
        #1;
        check_all(tag);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        th_tab[0] = 0;
        th_tab[1] = 6;
        th_tab[2] = 12;
        th_tab[3] = 24;
        m_state   = 0;
        m_changed = 0;

        // 1: reset with a full reading held at the input
        rst_n   = 1'b0;
        battery = 5'd30;
        repeat (3) @(posedge clk);
        #1;
        check_all("reset");
        rst_n = 1'b1;
        step(30, "rel_first");
        check_eq("rel_state3", int'(state), 3);
        check_eq("rel_pulse", int'(changed), 1);
        step(30, "rel_second");
        check_eq("rel_nopulse", int'(changed), 0);

        // 2: descending sequence from FULL
        begin
            int seq[8] = '{30, 26, 16, 10, 8, 5, 3, 0};
            int exp[8] = '{3, 3, 2, 2, 1, 1, 0, 0};
            for (int i = 0; i < 8; i++) begin
                step(seq[i], "desc");
                check_eq("desc_table", int'(state), exp[i]);
            end
        end

        // 3: chatter around TH_MID while in MID
        step(14, "to_mid");
        begin
            int ch[5] = '{11, 12, 11, 10, 12};
            for (int i = 0; i < 5; i++) begin
                step(ch[i], "chatter");
                check_eq("chatter_hold", int'(state), 2);
                check_eq("chatter_nopulse", int'(changed), 0);
            end
        end
        step(9, "chatter_drop");
        check_eq("drop_low", int'(state), 1);
        check_eq("drop_pulse", int'(changed), 1);

        // 4: level skips both directions
        step(0, "to_crit");
        step(31, "skip_up");
        check_eq("skip_up_full", int'(state), 3);
        step(2, "skip_down");
        check_eq("skip_down_crit", int'(state), 0);
        check_eq("skip_down_critical", int'(critical), 1);

        // 5: asynchronous reset between edges
        step(28, "pre_async");
        check_eq("pre_async_full", int'(state), 3);
        async_reset("async");
        step(13, "post_async");
        check_eq("post_async_mid", int'(state), 2);

        // 6: threshold exactness
        step(0, "ex_crit");
        step(6, "ex_low");
        check_eq("ex_low_val", int'(state), 1);
        step(12, "ex_mid");
        check_eq("ex_mid_val", int'(state), 2);
        step(24, "ex_full");
        check_eq("ex_full_val", int'(state), 3);
        step(22, "ex_hold");
        check_eq("ex_hold_val", int'(state), 3);
        step(21, "ex_fall");
        check_eq("ex_fall_val", int'(state), 2);

        // Random readings, biased toward thresholds, with occasional async reset
        for (int i = 0; i < 400; i++) begin
            int b;
            int sel;
            sel = int'($urandom_range(0, 9));
            if (sel < 4) begin
                b = th_tab[int'($urandom_range(1, 3))] + int'($urandom_range(0, 4)) - 3;
            end else begin
                b = int'($urandom_range(0, 31));
            end
            if (b < 0) b = 0;
            step(b, "rand");
            if ($urandom_range(0, 49) == 0) begin
                async_reset("rand_rst");
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
